// File: rtl/avg_sched_pkg.sv
// Shared types and defaults for the round-robin scheduler and its
// 4-sample averaging engine.
package avg_sched_pkg;

    localparam int DEF_W   = 8;
    localparam int DEF_NCH = 4;
    localparam int SUMW    = DEF_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EMIT
    } state_e;

    // A 4-sample sum needs two extra bits to never overflow.
    function automatic int sum_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/avg_sched_avg4_engine.sv
// Shared datapath: four sample slots, truncated mean and |mean - s3|,
// with registered results captured on a strobe.
module avg4_engine
    import avg_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [1:0]   idx_i,
    input  logic [W-1:0] din_i,
    input  logic         capture_i,
    output logic [W-1:0] avg_o,
    output logic [W-1:0] diff_o
);

    localparam int SW = sum_width(W);

    logic [W-1:0]  s_q [4];
    logic [W-1:0]  s3;
    logic [SW-1:0] sum;
    logic [W-1:0]  avg_d;
    logic [W-1:0]  diff_d;
    logic [W-1:0]  avg_q;
    logic [W-1:0]  diff_q;

    // NOTE: the slot array is small, so it is reset like any other register;
    // a large RAM-style array would normally be left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                s_q[i] <= '0;
            end
        end else if (load_i) begin
            s_q[idx_i] <= din_i;
        end
    end

    // The last sample is taken straight from the input on its load cycle so
    // the result can be captured on the same edge that stores it.
    always_comb begin
        s3     = (load_i && (idx_i == 2'd3)) ? din_i : s_q[3];
        sum    = SW'(s_q[0]) + SW'(s_q[1]) + SW'(s_q[2]) + SW'(s3);
        avg_d  = sum[SW-1:2];
        diff_d = (avg_d >= s3) ? (avg_d - s3) : (s3 - avg_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avg_q  <= '0;
            diff_q <= '0;
        end else if (capture_i) begin
            avg_q  <= avg_d;
            diff_q <= diff_d;
        end
    end

    assign avg_o  = avg_q;
    assign diff_o = diff_q;

endmodule

// File: rtl/avg_sched.sv
// Round-robin arbiter feeding NCH serial 4-sample bursts into one shared
// averaging engine; one result pulse per completed burst.
module avg_sched
    import avg_sched_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W,
    parameter int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*W-1:0] sample,
    output logic [NCH-1:0]   grant,
    output logic             busy,
    output logic             res_valid,
    output logic [CW-1:0]    res_ch,
    output logic [W-1:0]     res_avg,
    output logic [W-1:0]     res_diff
);

    state_e         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [CW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NCH-1:0] grant_q, grant_d;
    logic [CW-1:0]  res_ch_q, res_ch_d;

    logic           sel_found;
    logic [CW-1:0]  sel_ch;
    logic           load;
    logic           capture;
    logic [W-1:0]   owner_sample;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int off);
        int c;
        c = int'(base) + off;
        if (c >= NCH) begin
            c = c - NCH;
        end
        return CW'(c);
    endfunction

    // Rotate-priority pick: first requester at or after rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!sel_found && req[wrap_add(rr_ptr_q, i)]) begin
                sel_found = 1'b1;
                sel_ch    = wrap_add(rr_ptr_q, i);
            end
        end
    end

    assign owner_sample = sample[int'(owner_q)*W +: W];

    // NOTE: every signal gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        res_ch_d = res_ch_q;
        load     = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (sel_found) begin
                    owner_d = sel_ch;
                    grant_d = {{(NCH-1){1'b0}}, 1'b1} << sel_ch;
                    beat_d  = 2'd0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (req[owner_q] && grant_q[owner_q]) begin
                    load   = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        grant_d  = '0;
                        capture  = 1'b1;
                        res_ch_d = owner_q;
                        state_d  = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                rr_ptr_d = wrap_add(owner_q, 1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= 2'd0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            res_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            res_ch_q <= res_ch_d;
        end
    end

    avg4_engine #(.W(W)) u_engine (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .idx_i     (beat_q),
        .din_i     (owner_sample),
        .capture_i (capture),
        .avg_o     (res_avg),
        .diff_o    (res_diff)
    );

    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_EMIT);
    assign res_ch    = res_ch_q;

endmodule
